// File: rtl/neopixel_pkg.sv
// Shared definitions for the two-port NeoPixel controller arbiter:
// FSM state encoding, port count, bus widths and counter widths.
package neopixel_pkg;

  localparam int NP_PORTS   = 2;
  localparam int NP_ADDR_W  = 32;
  localparam int NP_DATA_W  = 32;
  localparam int NP_BEAT_W  = 8;
  localparam int NP_STALL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } np_state_e;

endpackage

// File: rtl/neopixel_ctrl_arbiter_if.sv
// Bundle of requester-side and pixel-controller-side signals of the arbiter.
// Port i of the packed request buses lives at [32i+31:32i].
interface neopixel_ctrl_arbiter_if;
  import neopixel_pkg::*;

  logic [NP_PORTS-1:0]           req_valid;
  logic [NP_PORTS-1:0]           req_write_en;
  logic [NP_PORTS*NP_ADDR_W-1:0] req_address;
  logic [NP_PORTS*NP_DATA_W-1:0] req_write_data;
  logic [NP_PORTS-1:0]           req_grant;
  logic [NP_PORTS-1:0]           req_ready;
  logic                          ctrl_write_en;
  logic [NP_ADDR_W-1:0]          ctrl_address;
  logic [NP_DATA_W-1:0]          ctrl_write_data;
  logic                          ctrl_ready;
  logic                          frame_done;
  logic                          timeout_err;

  // Arbiter side
  modport slave (
    input  req_valid, req_write_en, req_address, req_write_data, ctrl_ready,
    output req_grant, req_ready, ctrl_write_en, ctrl_address, ctrl_write_data,
           frame_done, timeout_err
  );

  // Requesters plus pixel controller side
  modport master (
    output req_valid, req_write_en, req_address, req_write_data, ctrl_ready,
    input  req_grant, req_ready, ctrl_write_en, ctrl_address, ctrl_write_data,
           frame_done, timeout_err
  );

endinterface

// File: rtl/neopixel_ctrl_arbiter.sv
// Two-port round-robin arbiter in front of a NeoPixel controller.
// A granted port owns the controller for a whole frame of C_PIXELS beats;
// the grant is only released by frame completion or by a stall timeout.
module neopixel_ctrl_arbiter
  import neopixel_pkg::*;
#(
  parameter int C_PIXELS  = 12,
  parameter int C_TIMEOUT = 1024
) (
  input  logic                  axi_clock,
  input  logic                  axi_resetn,
  neopixel_ctrl_arbiter_if.slave bus
);

  localparam logic [NP_BEAT_W-1:0]  LP_PIXELS  = NP_BEAT_W'(C_PIXELS);
  localparam logic [NP_STALL_W-1:0] LP_TIMEOUT = NP_STALL_W'(C_TIMEOUT);

  np_state_e               r_state;
  np_state_e               w_state_nxt;
  logic [NP_PORTS-1:0]     r_grant;
  logic [NP_PORTS-1:0]     w_grant_nxt;
  logic                    r_last;          // index of the port granted last
  logic                    w_last_nxt;
  logic [NP_BEAT_W-1:0]    r_beat_cnt;
  logic [NP_BEAT_W-1:0]    w_beat_nxt;
  logic [NP_STALL_W-1:0]   r_stall_cnt;
  logic [NP_STALL_W-1:0]   w_stall_nxt;
  logic                    r_frame_done;
  logic                    w_frame_done_nxt;
  logic                    r_timeout_err;
  logic                    w_timeout_err_nxt;
  logic                    r_ctrl_we;
  logic [NP_ADDR_W-1:0]    r_ctrl_addr;
  logic [NP_DATA_W-1:0]    r_ctrl_data;

  logic [NP_PORTS-1:0]     w_ready;
  logic [NP_PORTS-1:0]     w_accept_vec;
  logic                    w_accept;
  logic [NP_ADDR_W-1:0]    w_beat_addr;
  logic [NP_DATA_W-1:0]    w_beat_data;

  // Ready follows the grant only while the controller can take a beat in GRANT
  always_comb begin
    w_ready = {NP_PORTS{1'b0}};
    if ((r_state == ST_GRANT) && bus.ctrl_ready) begin
      w_ready = r_grant;
    end else begin
      w_ready = {NP_PORTS{1'b0}};
    end
    w_accept_vec = bus.req_write_en & w_ready;
    w_accept     = |w_accept_vec;
  end

  // Select address/data of the granted port
  always_comb begin
    w_beat_addr = bus.req_address[NP_ADDR_W-1:0];
    w_beat_data = bus.req_write_data[NP_DATA_W-1:0];
    if (r_grant[1]) begin
      w_beat_addr = bus.req_address[2*NP_ADDR_W-1:NP_ADDR_W];
      w_beat_data = bus.req_write_data[2*NP_DATA_W-1:NP_DATA_W];
    end else begin
      w_beat_addr = bus.req_address[NP_ADDR_W-1:0];
      w_beat_data = bus.req_write_data[NP_DATA_W-1:0];
    end
  end

  // Next-state, grant, counters and pulse outputs
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_last_nxt        = r_last;
    w_beat_nxt        = r_beat_cnt;
    w_stall_nxt       = r_stall_cnt;
    w_frame_done_nxt  = 1'b0;
    w_timeout_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = {NP_PORTS{1'b0}};
        w_beat_nxt  = {NP_BEAT_W{1'b0}};
        w_stall_nxt = {NP_STALL_W{1'b0}};
        if (bus.req_valid == 2'b11) begin
          // Contention: the port not served last wins
          w_state_nxt = ST_GRANT;
          if (r_last) begin
            w_grant_nxt = 2'b01;
            w_last_nxt  = 1'b0;
          end else begin
            w_grant_nxt = 2'b10;
            w_last_nxt  = 1'b1;
          end
        end else if (bus.req_valid != 2'b00) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = bus.req_valid;
          w_last_nxt  = bus.req_valid[1];
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_accept) begin
          w_stall_nxt = {NP_STALL_W{1'b0}};
          if ((r_beat_cnt + 8'd1) == LP_PIXELS) begin
            w_state_nxt      = ST_DONE;
            w_grant_nxt      = {NP_PORTS{1'b0}};
            w_beat_nxt       = {NP_BEAT_W{1'b0}};
            w_frame_done_nxt = 1'b1;
          end else begin
            w_beat_nxt = r_beat_cnt + 8'd1;
          end
        end else if (bus.ctrl_ready) begin
          // Controller is willing but the owner sends nothing: a stall cycle
          if ((r_stall_cnt + 16'd1) == LP_TIMEOUT) begin
            w_state_nxt       = ST_ABORT;
            w_grant_nxt       = {NP_PORTS{1'b0}};
            w_beat_nxt        = {NP_BEAT_W{1'b0}};
            w_stall_nxt       = {NP_STALL_W{1'b0}};
            w_timeout_err_nxt = 1'b1;
          end else begin
            w_stall_nxt = r_stall_cnt + 16'd1;
          end
        end else begin
          // Back-pressure from the controller is not the owner's fault
          w_stall_nxt = r_stall_cnt;
        end
      end
      ST_DONE, ST_ABORT: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = {NP_PORTS{1'b0}};
        w_beat_nxt  = {NP_BEAT_W{1'b0}};
        w_stall_nxt = {NP_STALL_W{1'b0}};
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = {NP_PORTS{1'b0}};
        w_beat_nxt  = {NP_BEAT_W{1'b0}};
        w_stall_nxt = {NP_STALL_W{1'b0}};
      end
    endcase
  end

  // FSM state, grant ownership and counters
  always_ff @(posedge axi_clock or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state       <= ST_IDLE;
      r_grant       <= {NP_PORTS{1'b0}};
      r_last        <= 1'b1;
      r_beat_cnt    <= {NP_BEAT_W{1'b0}};
      r_stall_cnt   <= {NP_STALL_W{1'b0}};
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_last        <= w_last_nxt;
      r_beat_cnt    <= w_beat_nxt;
      r_stall_cnt   <= w_stall_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  // Registered beat forwarding to the controller; address/data hold when idle
  always_ff @(posedge axi_clock or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_ctrl_we   <= 1'b0;
      r_ctrl_addr <= {NP_ADDR_W{1'b0}};
      r_ctrl_data <= {NP_DATA_W{1'b0}};
    end else begin
      r_ctrl_we <= w_accept;
      if (w_accept) begin
        r_ctrl_addr <= w_beat_addr;
        r_ctrl_data <= w_beat_data;
      end
    end
  end

  assign bus.req_grant       = r_grant;
  assign bus.req_ready       = w_ready;
  assign bus.ctrl_write_en   = r_ctrl_we;
  assign bus.ctrl_address    = r_ctrl_addr;
  assign bus.ctrl_write_data = r_ctrl_data;
  assign bus.frame_done      = r_frame_done;
  assign bus.timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_neopixel_ctrl_arbiter.sv
// Directed self-checking bench for neopixel_ctrl_arbiter (C_PIXELS=12,
// C_TIMEOUT=1024). Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point, so each tick() is one clock cycle.
module tb_neopixel_ctrl_arbiter;
  import neopixel_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   n_pass = 0;
  int   n_total = 0;
  logic tout_seen;
  int   we_pulses;

  neopixel_ctrl_arbiter_if bus ();

  neopixel_ctrl_arbiter #(.C_PIXELS(12), .C_TIMEOUT(1024)) dut (
    .axi_clock  (clk),
    .axi_resetn (rstn),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req_write_en[0]       = we;
      bus.req_address[31:0]     = a;
      bus.req_write_data[31:0]  = d;
    end else begin
      bus.req_write_en[1]       = we;
      bus.req_address[63:32]    = a;
      bus.req_write_data[63:32] = d;
    end
  endtask

  // Advance n cycles, recording any timeout pulse and controller writes
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.timeout_err === 1'b1) tout_seen = 1'b1;
      if (bus.ctrl_write_en === 1'b1) we_pulses++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, bus.req_grant, 64'd0);
    check({tag, "_ready"}, bus.req_ready, 64'd0);
    check({tag, "_we"},    bus.ctrl_write_en, 64'd0);
    check({tag, "_addr"},  bus.ctrl_address, 64'd0);
    check({tag, "_data"},  bus.ctrl_write_data, 64'd0);
    check({tag, "_done"},  bus.frame_done, 64'd0);
    check({tag, "_tout"},  bus.timeout_err, 64'd0);
  endtask

  initial begin
    rstn               = 1'b0;
    bus.req_valid      = 2'b00;
    bus.req_write_en   = 2'b00;
    bus.req_address    = 64'd0;
    bus.req_write_data = 64'd0;
    bus.ctrl_ready     = 1'b0;
    tout_seen          = 1'b0;
    we_pulses          = 0;

    // ---- reset state
    #2;
    check_all_zero("reset");
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("idle_grant", bus.req_grant, 64'd0);

    // ---- both ports valid from reset: port 0 first, port 1 strobes ignored
    bus.req_valid  = 2'b11;
    bus.ctrl_ready = 1'b1;
    set_port(1, 1'b1, 32'hAAAA_0000, 32'h5555_0000);
    set_port(0, 1'b1, 32'd0, 32'h100);
    tick();
    check("rr0_grant", bus.req_grant, 64'h1);
    check("rr0_ready", bus.req_ready, 64'h1);
    check("rr0_we_idle", bus.ctrl_write_en, 64'd0);
    for (int k = 0; k < 12; k++) begin
      set_port(0, 1'b1, k, 32'h100 + k);
      if (k == 5) bus.req_valid = 2'b10;   // owner drops valid mid-frame
      if (k == 8) bus.req_valid = 2'b11;
      tick();
      check($sformatf("f0_we_%0d", k), bus.ctrl_write_en, 64'd1);
      check($sformatf("f0_addr_%0d", k), bus.ctrl_address, k);
      check($sformatf("f0_data_%0d", k), bus.ctrl_write_data, 64'h100 + k);
      if (k < 11) begin
        check($sformatf("f0_grant_%0d", k), bus.req_grant, 64'h1);
        check($sformatf("f0_nodone_%0d", k), bus.frame_done, 64'd0);
      end
    end
    check("f0_done", bus.frame_done, 64'd1);
    check("f0_done_grant", bus.req_grant, 64'd0);
    check("f0_done_ready", bus.req_ready, 64'd0);
    set_port(0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 32'd0, 32'd0);
    tick();
    check("gap_done", bus.frame_done, 64'd0);
    check("gap_grant", bus.req_grant, 64'd0);
    check("gap_we", bus.ctrl_write_en, 64'd0);
    tick();
    check("rr1_grant", bus.req_grant, 64'h2);
    check("hold_addr", bus.ctrl_address, 64'd11);

    // ---- port 1 sends 3 beats then stalls -> timeout
    for (int j = 0; j < 3; j++) begin
      set_port(1, 1'b1, 32'h200 + j, 32'hD00 + j);
      tick();
      check($sformatf("p1_we_%0d", j), bus.ctrl_write_en, 64'd1);
      check($sformatf("p1_addr_%0d", j), bus.ctrl_address, 64'h200 + j);
    end
    set_port(1, 1'b0, 32'd0, 32'd0);
    set_port(0, 1'b1, 32'hBAD, 32'hBAD);   // non-owner strobes
    tout_seen = 1'b0;
    we_pulses = 0;
    run(1023);
    check("stall_no_tout", tout_seen, 64'd0);
    check("stall_no_we", we_pulses, 64'd0);
    check("stall_grant", bus.req_grant, 64'h2);
    tick();
    check("tout_pulse", bus.timeout_err, 64'd1);
    check("tout_grant", bus.req_grant, 64'd0);
    check("tout_we", bus.ctrl_write_en, 64'd0);
    set_port(0, 1'b0, 32'd0, 32'd0);
    tick();
    check("tout_clear", bus.timeout_err, 64'd0);
    tick();
    check("after_tout_grant", bus.req_grant, 64'h1);

    // ---- port 0 frame with controller back-pressure and long stalls
    tout_seen = 1'b0;
    we_pulses = 0;
    set_port(0, 1'b1, 32'h400, 32'h400);
    run(4);
    set_port(0, 1'b0, 32'h400, 32'h400);
    run(600);
    bus.ctrl_ready = 1'b0;
    set_port(0, 1'b1, 32'h400, 32'h400);
    run(500);
    check("bp_ready", bus.req_ready, 64'd0);
    check("bp_pulses", we_pulses, 64'd4);
    bus.ctrl_ready = 1'b1;
    set_port(0, 1'b0, 32'h400, 32'h400);
    run(400);
    set_port(0, 1'b1, 32'h405, 32'h405);
    run(1);
    set_port(0, 1'b0, 32'h405, 32'h405);
    run(1000);
    set_port(0, 1'b1, 32'h40B, 32'h40B);
    run(7);
    check("bp_done", bus.frame_done, 64'd1);
    check("bp_addr", bus.ctrl_address, 64'h40B);
    set_port(0, 1'b0, 32'd0, 32'd0);
    bus.req_valid = 2'b01;
    run(1);
    check("bp_no_tout", tout_seen, 64'd0);
    check("bp_pulse_total", we_pulses, 64'd12);
    tick();
    check("f3_grant", bus.req_grant, 64'h1);

    // ---- reset mid-frame after 5 beats
    for (int j = 0; j < 5; j++) begin
      set_port(0, 1'b1, 32'h500 + j, 32'h500 + j);
      tick();
    end
    check("pre_rst_we", bus.ctrl_write_en, 64'd1);
    rstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    set_port(0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    check_all_zero("held_rst");
    rstn = 1'b1;
    tick();
    check("post_rst_grant", bus.req_grant, 64'h1);
    for (int k = 0; k < 12; k++) begin
      set_port(0, 1'b1, 32'h600 + k, 32'h700 + k);
      tick();
      check($sformatf("f4_addr_%0d", k), bus.ctrl_address, 64'h600 + k);
      if (k == 10) check("f4_nodone_11", bus.frame_done, 64'd0);
    end
    check("f4_done", bus.frame_done, 64'd1);
    set_port(0, 1'b0, 32'd0, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
